// File: rtl/ub_access_arbiter_if.sv
// rtl/ub_access_arbiter_if.sv - requester and unified-buffer signal bundle for ub_access_arbiter
interface ub_access_arbiter_if #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 256,
    parameter int ADDR_W = 9,
    parameter int LEN_W  = 5
);
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH-1:0]        ch_we;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*LEN_W-1:0]  ch_len;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;
    logic [NUM_CH-1:0]        ch_gnt;
    logic [NUM_CH-1:0]        ch_beat;
    logic [NUM_CH-1:0]        ch_done;
    logic [NUM_CH-1:0]        ch_rvalid;
    logic [DATA_W-1:0]        ch_rdata;
    logic                     ub_rd_en;
    logic                     ub_wr_en;
    logic [ADDR_W-1:0]        ub_addr;
    logic [DATA_W-1:0]        ub_wr_data;
    logic [DATA_W-1:0]        ub_rd_data;
    logic                     busy;
    logic [2:0]               active_ch;

    modport slave (
        input  ch_req, ch_we, ch_addr, ch_len, ch_wdata, ub_rd_data,
        output ch_gnt, ch_beat, ch_done, ch_rvalid, ch_rdata,
               ub_rd_en, ub_wr_en, ub_addr, ub_wr_data, busy, active_ch
    );

    modport master (
        output ch_req, ch_we, ch_addr, ch_len, ch_wdata, ub_rd_data,
        input  ch_gnt, ch_beat, ch_done, ch_rvalid, ch_rdata,
               ub_rd_en, ub_wr_en, ub_addr, ub_wr_data, busy, active_ch
    );
endinterface

// File: rtl/ub_access_arbiter.sv
// rtl/ub_access_arbiter.sv - N-channel burst arbiter in front of the unified buffer access port
module ub_access_arbiter #(
    parameter int NUM_CH  = 3,
    parameter int DATA_W  = 256,
    parameter int ADDR_W  = 9,
    parameter int LEN_W   = 5,
    parameter int RD_LAT  = 1,
    parameter int RR_MODE = 1
) (
    input  logic               clk,
    input  logic               rst,
    ub_access_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

    state_t              state, state_next;
    logic [2:0]          gnt_idx;
    logic [2:0]          win_idx;
    logic [2:0]          rr_ptr;
    logic                win_found;
    logic [LEN_W-1:0]    win_len;
    logic [ADDR_W-1:0]   cur_addr;
    logic [LEN_W-1:0]    remaining;
    logic                dir;
    logic                in_burst;
    logic [NUM_CH-1:0]   gnt_vec;
    logic [RD_LAT-1:0]   vld_pipe;
    logic [2:0]          tag_pipe [RD_LAT];

    // Winner selection: rotating search from rr_ptr, or lowest index first.
    always_comb begin : arbitrate
        win_idx   = '0;
        win_found = 1'b0;
        if (RR_MODE != 0) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!win_found && bus.ch_req[(int'(rr_ptr) + k) % NUM_CH]) begin
                    win_found = 1'b1;
                    win_idx   = 3'((int'(rr_ptr) + k) % NUM_CH);
                end
            end
        end else begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                if (bus.ch_req[k]) begin
                    win_found = 1'b1;
                    win_idx   = 3'(k);
                end
            end
        end
        win_len = bus.ch_len[int'(win_idx)*LEN_W +: LEN_W];
        if (win_len == '0) begin
            win_len = LEN_W'(1);
        end
    end

    always_comb begin : fsm_comb
        state_next = state;
        in_burst   = (state == BURST);
        case (state)
            IDLE:    if (win_found) state_next = BURST;
            BURST:   if (remaining == LEN_W'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        gnt_vec        = in_burst ? (ONE << gnt_idx) : '0;
        bus.ch_gnt     = gnt_vec;
        bus.ch_beat    = gnt_vec;
        bus.ch_done    = (in_burst && remaining == LEN_W'(1)) ? gnt_vec : '0;
        bus.busy       = in_burst;
        bus.active_ch  = in_burst ? gnt_idx : 3'd0;
        bus.ub_rd_en   = in_burst && !dir;
        bus.ub_wr_en   = in_burst && dir;
        bus.ub_addr    = in_burst ? cur_addr : '0;
        bus.ub_wr_data = in_burst ? bus.ch_wdata[int'(gnt_idx)*DATA_W +: DATA_W] : '0;
        bus.ch_rvalid  = vld_pipe[RD_LAT-1] ? (ONE << tag_pipe[RD_LAT-1]) : '0;
        bus.ch_rdata   = vld_pipe[RD_LAT-1] ? bus.ub_rd_data : '0;
    end

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin : datapath
        if (rst) begin
            gnt_idx   <= '0;
            rr_ptr    <= '0;
            cur_addr  <= '0;
            remaining <= '0;
            dir       <= 1'b0;
            vld_pipe  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            if (state == IDLE && win_found) begin
                gnt_idx   <= win_idx;
                cur_addr  <= bus.ch_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                remaining <= win_len;
                dir       <= bus.ch_we[win_idx];
                if (RR_MODE != 0) begin
                    rr_ptr <= (win_idx == 3'(NUM_CH - 1)) ? 3'd0 : win_idx + 3'd1;
                end
            end else if (state == BURST) begin
                cur_addr  <= cur_addr + ADDR_W'(1);
                remaining <= remaining - LEN_W'(1);
            end
            // Read tags travel alongside the UB read latency so data returns to its issuer.
            vld_pipe[0] <= in_burst && !dir;
            tag_pipe[0] <= gnt_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end
endmodule

// File: tb/tb_ub_access_arbiter.sv
// tb/tb_ub_access_arbiter.sv - directed bench for round-robin and fixed-priority ub_access_arbiter
module tb_ub_access_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   req;
    logic [2:0]   we;
    logic [26:0]  addr;
    logic [14:0]  len;
    logic [767:0] wdata;
    int           n_cmp;
    int           n_bad;

    logic [255:0] rr_pipe [2];
    logic [255:0] fp_pipe;

    always #5 clk = ~clk;

    ub_access_arbiter_if #(.NUM_CH(3), .DATA_W(256), .ADDR_W(9), .LEN_W(5)) if_rr ();
    ub_access_arbiter_if #(.NUM_CH(3), .DATA_W(256), .ADDR_W(9), .LEN_W(5)) if_fp ();

    ub_access_arbiter #(.NUM_CH(3), .DATA_W(256), .ADDR_W(9), .LEN_W(5), .RD_LAT(2), .RR_MODE(1))
        dut_rr (.clk(clk), .rst(rst), .bus(if_rr.slave));
    ub_access_arbiter #(.NUM_CH(3), .DATA_W(256), .ADDR_W(9), .LEN_W(5), .RD_LAT(1), .RR_MODE(0))
        dut_fp (.clk(clk), .rst(rst), .bus(if_fp.slave));

    assign if_rr.ch_req   = req;
    assign if_rr.ch_we    = we;
    assign if_rr.ch_addr  = addr;
    assign if_rr.ch_len   = len;
    assign if_rr.ch_wdata = wdata;
    assign if_fp.ch_req   = req;
    assign if_fp.ch_we    = we;
    assign if_fp.ch_addr  = addr;
    assign if_fp.ch_len   = len;
    assign if_fp.ch_wdata = wdata;

    function automatic logic [255:0] mem_word(input logic [8:0] a);
        return {8{32'hD000_0000 | {23'd0, a}}};
    endfunction

    function automatic logic [255:0] beat_word(input int i);
        return {8{32'h1000_0000 + 32'(i)}};
    endfunction

    // UB model: read data appears RD_LAT cycles after the read enable.
    assign if_rr.ub_rd_data = rr_pipe[1];
    assign if_fp.ub_rd_data = fp_pipe;
    always @(posedge clk) begin
        rr_pipe[0] <= if_rr.ub_rd_en ? mem_word(if_rr.ub_addr) : '0;
        rr_pipe[1] <= rr_pipe[0];
        fp_pipe    <= if_fp.ub_rd_en ? mem_word(if_fp.ub_addr) : '0;
    end

    wire [26:0] st_rr = {if_rr.busy, if_rr.active_ch, if_rr.ch_gnt, if_rr.ch_beat, if_rr.ch_done,
                         if_rr.ch_rvalid, if_rr.ub_rd_en, if_rr.ub_wr_en, if_rr.ub_addr};
    wire [26:0] st_fp = {if_fp.busy, if_fp.active_ch, if_fp.ch_gnt, if_fp.ch_beat, if_fp.ch_done,
                         if_fp.ch_rvalid, if_fp.ub_rd_en, if_fp.ub_wr_en, if_fp.ub_addr};

    function automatic logic [26:0] st(input logic [2:0] g, input logic [2:0] d, input logic [2:0] rv,
                                       input logic wr, input logic [8:0] a);
        logic [2:0] act;
        act = g[2] ? 3'd2 : (g[1] ? 3'd1 : 3'd0);
        return {|g, act, g, g, d, rv, (|g) & ~wr, (|g) & wr, (|g) ? a : 9'd0};
    endfunction

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] rr_g [15] = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b100, 3'b100, 3'b000, 3'b001,
                              3'b001, 3'b000, 3'b100, 3'b100, 3'b000, 3'b100, 3'b100};
    logic [2:0] fp_g [15] = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b001, 3'b001, 3'b000, 3'b001,
                              3'b001, 3'b000, 3'b001, 3'b001, 3'b000, 3'b100, 3'b100};
    logic [2:0] rv_rr [9] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b000, 3'b010, 3'b000};
    logic [8:0] ra_rr [9] = '{9'h0, 9'h0, 9'h0, 9'h10, 9'h11, 9'h12, 9'h0, 9'h40, 9'h0};
    logic [2:0] rv_fp [9] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b000, 3'b010, 3'b000, 3'b000};
    logic [8:0] ra_fp [9] = '{9'h0, 9'h0, 9'h10, 9'h11, 9'h12, 9'h0, 9'h40, 9'h0, 9'h0};

    function automatic logic [2:0] done_of(input logic [2:0] g [15], input int c);
        return (g[c] != 3'b000 && g[c-1] == g[c]) ? g[c] : 3'b000;
    endfunction

    function automatic logic [8:0] addr_of(input logic [2:0] g, input logic [2:0] d);
        if (g == 3'b000) return 9'h0;
        return (g == 3'b001 ? 9'h20 : 9'h30) + ((d != 3'b000) ? 9'd1 : 9'd0);
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        req   = '0;
        we    = '0;
        addr  = '0;
        len   = '0;
        wdata = {{8{32'h5555_5555}}, 256'd0, {8{32'hAAAA_AAAA}}};
        rst   = 1'b1;

        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("reset_rr", 256'(st_rr), 256'(0));
            check_eq("reset_fp", 256'(st_fp), 256'(0));
            check_eq("reset_rdata", if_rr.ch_rdata, '0);
            check_eq("reset_wdata", if_fp.ub_wr_data, '0);
        end
        rst = 1'b0;
        tick();
        check_eq("idle_rr", 256'(st_rr), 256'(0));

        // Write burst on ch1 across the address wrap; request dropped after grant.
        we = 3'b010; addr[9 +: 9] = 9'h1FE; len[5 +: 5] = 5'd4; req = 3'b010;
        wdata[256 +: 256] = beat_word(0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("wr_rr", 256'(st_rr), 256'(st(3'b010, (i == 3) ? 3'b010 : 3'b000, 3'b000, 1'b1, 9'(9'h1FE + i))));
            check_eq("wr_fp", 256'(st_fp), 256'(st(3'b010, (i == 3) ? 3'b010 : 3'b000, 3'b000, 1'b1, 9'(9'h1FE + i))));
            check_eq("wr_data", if_rr.ub_wr_data, beat_word(i));
            req = 3'b000;
            wdata[256 +: 256] = beat_word(i + 1);
        end
        tick();
        check_eq("wr_end_rr", 256'(st_rr), 256'(0));
        check_eq("wr_end_fp", 256'(st_fp), 256'(0));

        // Zero length behaves as a single beat.
        len[5 +: 5] = 5'd0; addr[9 +: 9] = 9'h005; req = 3'b010;
        tick();
        check_eq("len0_rr", 256'(st_rr), 256'(st(3'b010, 3'b010, 3'b000, 1'b1, 9'h005)));
        check_eq("len0_fp", 256'(st_fp), 256'(st(3'b010, 3'b010, 3'b000, 1'b1, 9'h005)));
        req = 3'b000;
        tick();
        check_eq("len0_end", 256'(st_rr), 256'(0));

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // ch0 and ch2 contend: round-robin alternates, fixed priority starves ch2.
        we = 3'b101; addr = {9'h30, 9'h0, 9'h20}; len = {5'd2, 5'd0, 5'd2}; req = 3'b101;
        for (int c = 1; c < 15; c++) begin
            tick();
            check_eq($sformatf("rr_c%0d", c), 256'(st_rr),
                     256'(st(rr_g[c], done_of(rr_g, c), 3'b000, 1'b1, addr_of(rr_g[c], done_of(rr_g, c)))));
            check_eq($sformatf("fp_c%0d", c), 256'(st_fp),
                     256'(st(fp_g[c], done_of(fp_g, c), 3'b000, 1'b1, addr_of(fp_g[c], done_of(fp_g, c)))));
            if (c == 11) req = 3'b100;
            if (c == 13) req = 3'b000;
        end
        tick();
        check_eq("arb_end", 256'({st_rr, st_fp}), 256'(0));

        // Reads on ch0 then ch1; returns tagged after each latency.
        we = 3'b000; addr = {9'h0, 9'h40, 9'h10}; len = {5'd0, 5'd1, 5'd3}; req = 3'b011;
        for (int c = 1; c < 9; c++) begin
            tick();
            check_eq($sformatf("rv_rr_c%0d", c), 256'(if_rr.ch_rvalid), 256'(rv_rr[c]));
            check_eq($sformatf("rd_rr_c%0d", c), if_rr.ch_rdata, (rv_rr[c] != 0) ? mem_word(ra_rr[c]) : '0);
            check_eq($sformatf("rv_fp_c%0d", c), 256'(if_fp.ch_rvalid), 256'(rv_fp[c]));
            check_eq($sformatf("rd_fp_c%0d", c), if_fp.ch_rdata, (rv_fp[c] != 0) ? mem_word(ra_fp[c]) : '0);
            check_eq($sformatf("rgnt_c%0d", c), 256'({if_rr.ch_gnt, if_fp.ch_gnt}),
                     256'((c <= 3) ? 6'b001001 : (c == 5) ? 6'b010010 : 6'b000000));
            if (c == 1) req = 3'b010;
            if (c == 5) req = 3'b000;
        end

        // Reset during an 8-beat read on ch2; request stays high.
        addr[18 +: 9] = 9'h80; len[10 +: 5] = 5'd8; req = 3'b100;
        for (int c = 1; c < 4; c++) begin
            tick();
            check_eq($sformatf("mid_rr_c%0d", c), 256'({if_rr.ch_gnt, if_rr.ch_done, if_rr.ub_rd_en, if_rr.ub_addr}),
                     256'({3'b100, 3'b000, 1'b1, 9'(9'h80 + c - 1)}));
            check_eq($sformatf("mid_fp_c%0d", c), 256'({if_fp.ch_gnt, if_fp.ch_done, if_fp.ub_rd_en, if_fp.ub_addr}),
                     256'({3'b100, 3'b000, 1'b1, 9'(9'h80 + c - 1)}));
        end
        rst = 1'b1;
        tick();
        check_eq("mid_rst_rr", 256'(st_rr), 256'(0));
        check_eq("mid_rst_fp", 256'(st_fp), 256'(0));
        check_eq("mid_rst_rdata", if_rr.ch_rdata | if_fp.ch_rdata, '0);
        rst = 1'b0;
        tick();
        check_eq("regrant_rr", 256'(st_rr), 256'(st(3'b100, 3'b000, 3'b000, 1'b0, 9'h80)));
        check_eq("regrant_fp", 256'(st_fp), 256'(st(3'b100, 3'b000, 3'b000, 1'b0, 9'h80)));
        req = 3'b000;
        for (int k = 0; k < 20 && (if_rr.busy || if_fp.busy); k++) begin
            tick();
        end
        check_eq("drain_idle", 256'({if_rr.busy, if_fp.busy}), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ub_access_arbiter.md
Name: ub_access_arbiter

Overview:
- Parametrised N-channel burst arbiter in front of the unified buffer (UB) single access port.
- Replaces the fixed two-source UART/legacy-DMA priority mux with registered arbitration across NUM_CH requesters (UART DMA, legacy DMA, controller, ...).
- Supports fixed-priority or round-robin arbitration, multi-beat bursts with address auto-increment, and per-channel tagged read-data return.

Parameters:
- NUM_CH, 3, number of requesting channels (2..8).
- DATA_W, 256, UB data width.
- ADDR_W, 9, UB address width.
- LEN_W, 5, burst-length field width; maximum burst is 2^LEN_W-1 beats.
- RD_LAT, 1, UB read latency in cycles (1..4).
- RR_MODE, 1, arbitration policy: 1 = round-robin, 0 = fixed priority (lowest index wins).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- ch_req  in  NUM_CH  per-channel burst request (level).
- ch_we  in  NUM_CH  per-channel direction: 1 = write, 0 = read.
- ch_addr  in  NUM_CH*ADDR_W  per-channel burst start address; channel i occupies slice [i*ADDR_W +: ADDR_W].
- ch_len  in  NUM_CH*LEN_W  per-channel beat count; 0 is treated as 1.
- ch_wdata  in  NUM_CH*DATA_W  per-channel write data for the current beat.
- ch_gnt  out  NUM_CH  one-hot grant, held for the whole burst.
- ch_beat  out  NUM_CH  one-hot pulse in each cycle a beat of that channel is issued to UB.
- ch_done  out  NUM_CH  one-cycle pulse on the last issued beat.
- ch_rvalid  out  NUM_CH  one-hot read-data-valid.
- ch_rdata  out  DATA_W  shared read-data return, qualified by ch_rvalid.
- ub_rd_en  out  1  UB read enable.
- ub_wr_en  out  1  UB write enable.
- ub_addr  out  ADDR_W  UB address.
- ub_wr_data  out  DATA_W  UB write data.
- ub_rd_data  in  DATA_W  UB read data, valid RD_LAT cycles after ub_rd_en.
- busy  out  1  high in BURST state.
- active_ch  out  3  index of the granted channel; 0 when idle.

Behaviour:
- Reset (rst sampled high at a clock edge):
  - state = IDLE; all outputs 0.
  - Round-robin pointer = 0.
  - Read-return tag pipeline flushed; no ch_rvalid for beats issued before reset.
  - Applies mid-burst: the burst is dropped with no ch_done.
- State machine, IDLE to BURST:
  - In IDLE, at an edge where any ch_req is high, select winner w.
  - Latch cur_addr = ch_addr[w], remaining = max(ch_len[w], 1), dir = ch_we[w].
  - Next state BURST with ch_gnt[w] = 1.
- Arbitration:
  - RR_MODE=1: search starts at pointer and wraps modulo NUM_CH; the first requester found wins; pointer := (w+1) mod NUM_CH at grant.
  - RR_MODE=0: lowest-index requester wins; pointer unused.
- BURST state, each cycle:
  - Exactly one beat issued: ub_wr_en = dir, ub_rd_en = !dir, ub_addr = cur_addr, ub_wr_data = ch_wdata[w] (combinational select of the granted slice).
  - ch_beat[w] = 1.
  - At the edge: cur_addr += 1, wrapping at 2^ADDR_W without fault; remaining -= 1.
  - When remaining == 1, ch_done[w] = 1 that cycle and the next state is IDLE; ch_gnt drops at the same edge.
- Burst commitment: deassertion of ch_req[w] during BURST is ignored and the burst completes. Requesters supply new wdata every ch_beat cycle.
- Inter-burst bubble:
  - Mandatory single IDLE cycle between bursts; throughput per burst is len beats in len+1 cycles.
  - No grant change mid-burst.
- Request timing: request asserted in cycle T produces its first beat in cycle T+1. ub_* and ch_gnt depend only on registered state, except the ub_wr_data slice select.
- Read return:
  - Shift pipeline of depth RD_LAT carries {valid, channel tag} for each read beat.
  - ch_rvalid[tag] = 1 and ch_rdata = ub_rd_data exactly RD_LAT cycles after the beat, including after the grant has moved to another channel.
  - ch_rdata = 0 when no ch_rvalid is asserted.
- Write beats produce no ch_rvalid.
- Simultaneous requests: exactly one grant; losers keep ch_req high and wait. ch_gnt is never multi-hot.
- active_ch = w while busy.

Test Plan:
- Reset/idle: rst high 2 cycles, no requests → all outputs 0, busy = 0.
- Single write burst: ch1 req, we=1, addr=0x1FE, len=4 → ch_gnt=3'b010 next cycle; ub_wr_en for 4 cycles at addresses 0x1FE, 0x1FF, 0x000, 0x001; ch_done on the 4th beat; then IDLE.
- Round-robin (RR_MODE=1): ch0 and ch2 hold req continuously, len=2 each → grant order ch0, ch2, ch0, ch2; one bubble between bursts; no ch_gnt overlap.
- Fixed priority (RR_MODE=0): same stimulus → ch0 is always granted while it requests; ch2 is granted only after ch0 drops req.
- Read tagging (RD_LAT=2): ch0 read len=3 at 0x10, then ch1 read len=1 → ch_rvalid[0] exactly 2 cycles after each ch0 beat, carrying data at 0x10..0x12; ch_rvalid[1] 2 cycles after its beat. Data is returned to the correct channel across the grant switch.
- Reset mid-burst: ch2 read len=8, rst asserted on the 3rd beat → next cycle all outputs 0; no ch_done; no ch_rvalid for in-flight beats; ch2 is granted again after release if req is still high.
